// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle between multicycle_ctrl and the datapath stages.
// The master side is the controller; the slave side is the datapath (yIF/yEX/yPC/...).
interface multicycle_ctrl_if #(
  parameter int unsigned RETIRE_W = 32
) ();

  logic [31:0]         ins;
  logic                zero;
  logic                IRWrite;
  logic                PCWrite;
  logic                INT;
  logic                isbranch;
  logic                isjump;
  logic                RegWrite;
  logic                ALUSrc;
  logic                MemRead;
  logic                MemWrite;
  logic                Mem2Reg;
  logic [2:0]          op;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  ins, zero,
    output IRWrite, PCWrite, INT, isbranch, isjump, RegWrite, ALUSrc,
           MemRead, MemWrite, Mem2Reg, op, halted, retired
  );

  modport slave (
    output ins, zero,
    input  IRWrite, PCWrite, INT, isbranch, isjump, RegWrite, ALUSrc,
           MemRead, MemWrite, Mem2Reg, op, halted, retired
  );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives Moore-style datapath controls from state plus latched IR, counts retired
// instructions and halts on unsupported opcodes.
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W = 32
) (
  input logic                clk,
  input logic                reset,
  multicycle_ctrl_if.master  bus
);

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJal    = 7'h6F;

  localparam logic [RETIRE_W-1:0] RetireOne = {{(RETIRE_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StInit,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } stateT;

  stateT               stateQ, stateD;
  logic [31:0]         irQ;
  logic [RETIRE_W-1:0] retiredQ;

  logic       irWrite, pcWrite, intSel, isBranch, isJump;
  logic       regWrite, aluSrc, memRead, memWrite, mem2Reg, haltFlag;
  logic [2:0] aluOp;
  logic       retire;

  logic [6:0] opcode;
  logic       legalOp;
  logic       aluSrcDec;
  logic [2:0] aluOpDec;

  assign opcode = irQ[6:0];

  // ALU operation for the latched instruction; R-type decodes {funct7[5], funct3}.
  function automatic logic [2:0] decodeAluOp(input logic [6:0] opc, input logic f7b5,
                                              input logic [2:0] f3);
    logic [2:0] res;
    res = 3'b010;
    if (opc == OpBranch) begin
      res = 3'b110;
    end else if (opc == OpReg) begin
      case ({f7b5, f3})
        4'b0_000: res = 3'b010;
        4'b1_000: res = 3'b110;
        4'b0_111: res = 3'b000;
        4'b0_110: res = 3'b001;
        4'b0_010: res = 3'b111;
        default:  res = 3'b010;
      endcase
    end
    return res;
  endfunction

  // Static decode of the IR, shared by EXEC, MEM and WB so ALUSrc/op stay held.
  always_comb begin
    legalOp   = (opcode == OpLoad) || (opcode == OpImm) || (opcode == OpStore) ||
                (opcode == OpReg) || (opcode == OpBranch) || (opcode == OpJal);
    aluSrcDec = !((opcode == OpReg) || (opcode == OpBranch));
    aluOpDec  = decodeAluOp(opcode, irQ[30], irQ[14:12]);
  end

  // State register, IR latch and retired counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StInit;
      irQ      <= '0;
      retiredQ <= '0;
    end else begin
      stateQ <= stateD;
      if (irWrite) begin
        irQ <= bus.ins;
      end
      if (retire) begin
        retiredQ <= retiredQ + RetireOne;
      end
    end
  end

  // Next-state and Moore control outputs.
  always_comb begin
    stateD   = stateQ;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    intSel   = 1'b0;
    isBranch = 1'b0;
    isJump   = 1'b0;
    regWrite = 1'b0;
    aluSrc   = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    mem2Reg  = 1'b0;
    haltFlag = 1'b0;
    aluOp    = 3'b000;
    case (stateQ)
      StInit: begin
        intSel  = 1'b1;
        pcWrite = 1'b1;
        stateD  = StFetch;
      end
      StFetch: begin
        irWrite = 1'b1;
        stateD  = StDecode;
      end
      StDecode: begin
        stateD = legalOp ? StExec : StHalt;
      end
      StExec: begin
        aluSrc = aluSrcDec;
        aluOp  = aluOpDec;
        if (opcode == OpBranch) begin
          // yPC picks taken/not-taken from zero; we only qualify the PC update.
          pcWrite  = 1'b1;
          isBranch = 1'b1;
          stateD   = StFetch;
        end else if ((opcode == OpLoad) || (opcode == OpStore)) begin
          stateD = StMem;
        end else begin
          stateD = StWb;
        end
      end
      StMem: begin
        aluSrc = aluSrcDec;
        aluOp  = aluOpDec;
        if (opcode == OpLoad) begin
          memRead = 1'b1;
          stateD  = StWb;
        end else begin
          memWrite = 1'b1;
          pcWrite  = 1'b1;
          stateD   = StFetch;
        end
      end
      StWb: begin
        aluSrc   = aluSrcDec;
        aluOp    = aluOpDec;
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        if (opcode == OpLoad) begin
          mem2Reg = 1'b1;
          memRead = 1'b1;
        end
        if (opcode == OpJal) begin
          isJump = 1'b1;
        end
        stateD = StFetch;
      end
      StHalt: begin
        haltFlag = 1'b1;
      end
      default: begin
        stateD = StInit;
      end
    endcase
  end

  // The PC update marks an instruction's final state; INIT's PC load is not a retire.
  assign retire = pcWrite && (stateQ != StInit);

  assign bus.IRWrite  = irWrite;
  assign bus.PCWrite  = pcWrite;
  assign bus.INT      = intSel;
  assign bus.isbranch = isBranch;
  assign bus.isjump   = isJump;
  assign bus.RegWrite = regWrite;
  assign bus.ALUSrc   = aluSrc;
  assign bus.MemRead  = memRead;
  assign bus.MemWrite = memWrite;
  assign bus.Mem2Reg  = mem2Reg;
  assign bus.op       = aluOp;
  assign bus.halted   = haltFlag;
  assign bus.retired  = retiredQ;

  // zero is consumed by yPC, and only opcode/funct bits of the IR steer control.
  logic unusedBits;
  assign unusedBits = ^{bus.zero, irQ[31], irQ[29:15], irQ[11:7]};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-cycle control
// vector and retire count; a negedge monitor pops and compares against two DUTs
// (32-bit and 4-bit retired counters) driven with the same instruction stream.
module tb_multicycle_ctrl;

  localparam logic [13:0] CInt  = 14'h2000;
  localparam logic [13:0] CPcw  = 14'h1000;
  localparam logic [13:0] CIrw  = 14'h0800;
  localparam logic [13:0] CBr   = 14'h0400;
  localparam logic [13:0] CJmp  = 14'h0200;
  localparam logic [13:0] CRw   = 14'h0100;
  localparam logic [13:0] CAsrc = 14'h0080;
  localparam logic [13:0] CMr   = 14'h0040;
  localparam logic [13:0] CMw   = 14'h0020;
  localparam logic [13:0] CM2r  = 14'h0010;
  localparam logic [13:0] CHalt = 14'h0001;

  typedef struct {
    logic [13:0] ctl;
    logic [31:0] ret;
    string       name;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] insV;
  logic        zeroV;

  expT         expQ[$];
  expT         monE;
  logic [31:0] expRet;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.RETIRE_W(32)) busA ();
  multicycle_ctrl_if #(.RETIRE_W(4))  busB ();

  assign busA.ins  = insV;
  assign busB.ins  = insV;
  assign busA.zero = zeroV;
  assign busB.zero = zeroV;

  multicycle_ctrl #(.RETIRE_W(32)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.master)
  );

  multicycle_ctrl #(.RETIRE_W(4)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.master)
  );

  function automatic logic [13:0] opF(input logic [2:0] o);
    return {10'b0, o, 1'b0};
  endfunction

  function automatic void chk(input logic [31:0] act, input logic [31:0] exp, input string n);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endfunction

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk({18'b0, busA.INT, busA.PCWrite, busA.IRWrite, busA.isbranch, busA.isjump,
           busA.RegWrite, busA.ALUSrc, busA.MemRead, busA.MemWrite, busA.Mem2Reg,
           busA.op, busA.halted}, {18'b0, monE.ctl}, {monE.name, " ctlA"});
      chk({18'b0, busB.INT, busB.PCWrite, busB.IRWrite, busB.isbranch, busB.isjump,
           busB.RegWrite, busB.ALUSrc, busB.MemRead, busB.MemWrite, busB.Mem2Reg,
           busB.op, busB.halted}, {18'b0, monE.ctl}, {monE.name, " ctlB"});
      chk(busA.retired, monE.ret, {monE.name, " retiredA"});
      chk({28'b0, busB.retired}, {28'b0, monE.ret[3:0]}, {monE.name, " retiredB"});
    end
  end

  // Expectation for the cycle following the next rising edge.
  task automatic step(input logic [13:0] c, input string n);
    expT e;
    @(posedge clk);
    #1;
    e.ctl  = c;
    e.ret  = expRet;
    e.name = n;
    expQ.push_back(e);
  endtask

  task automatic doReset(input int cycles);
    reset  = 1'b1;
    expRet = '0;
    repeat (cycles) step(CInt | CPcw, "init");
    reset = 1'b0;
  endtask

  // One legal instruction, FETCH through its final state; eop is the hand-decoded ALU op.
  task automatic runIns(input logic [31:0] i, input logic [2:0] eop, input string n);
    logic [13:0] ex;
    logic [6:0]  opc;
    opc  = i[6:0];
    insV = i;
    step(CIrw, {n, " fetch"});
    step(14'h0, {n, " decode"});
    // ins must be ignored outside FETCH
    insV  = ~i;
    zeroV = ~zeroV;
    ex = (((opc == 7'h33) || (opc == 7'h63)) ? 14'h0 : CAsrc) | opF(eop);
    case (opc)
      7'h63: begin
        step(ex | CPcw | CBr, {n, " exec"});
      end
      7'h03: begin
        step(ex, {n, " exec"});
        step(ex | CMr, {n, " mem"});
        step(ex | CRw | CPcw | CM2r | CMr, {n, " wb"});
      end
      7'h23: begin
        step(ex, {n, " exec"});
        step(ex | CMw | CPcw, {n, " mem"});
      end
      7'h6F: begin
        step(ex, {n, " exec"});
        step(ex | CRw | CPcw | CJmp, {n, " wb"});
      end
      default: begin
        step(ex, {n, " exec"});
        step(ex | CRw | CPcw, {n, " wb"});
      end
    endcase
    expRet = expRet + 32'd1;
  endtask

  initial begin
    reset  = 1'b1;
    insV   = '0;
    zeroV  = 1'b0;
    expRet = '0;

    doReset(2);

    runIns(32'h00A38333, 3'b010, "add");
    runIns(32'h40A38333, 3'b110, "sub");
    runIns(32'h00A3F333, 3'b000, "and");
    runIns(32'h00A3E333, 3'b001, "or");
    runIns(32'h00A3A333, 3'b111, "slt");
    runIns(32'h00A3C333, 3'b010, "xor");
    runIns(32'h00538313, 3'b010, "addi");
    runIns(32'h00002283, 3'b010, "lw");
    runIns(32'h00502023, 3'b010, "sw");
    runIns(32'h00000063, 3'b110, "beq");
    runIns(32'h0000006F, 3'b010, "jal");

    // Illegal opcode: halt, stay quiet, then reset clears it.
    insV = 32'h00000000;
    step(CIrw, "ill fetch");
    step(14'h0, "ill decode");
    insV = 32'h00A38333;
    repeat (12) step(CHalt, "halt");
    doReset(1);

    // Reset during MEM of lw.
    insV = 32'h00002283;
    step(CIrw, "lwrst fetch");
    step(14'h0, "lwrst decode");
    step(CAsrc | opF(3'b010), "lwrst exec");
    step(CAsrc | opF(3'b010) | CMr, "lwrst mem");
    doReset(1);

    runIns(32'h00A38333, 3'b010, "add2");

    // Reset during MEM of sw: the store must not retire.
    insV = 32'h00502023;
    step(CIrw, "swrst fetch");
    step(14'h0, "swrst decode");
    step(CAsrc | opF(3'b010), "swrst exec");
    step(CAsrc | opF(3'b010) | CMw | CPcw, "swrst mem");
    doReset(1);

    // 16 retires wrap the 4-bit counter to 0.
    for (int k = 0; k < 16; k++) begin
      runIns(32'h00A38333, 3'b010, "wrap");
    end
    step(CIrw, "wrap end");

    for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that replaces the per-instruction control values the single-cycle bench sets by hand. It sits directly upstream of the datapath stages (yIF, yID, yEX, yDM, yWB, yPC) and steps each fetched instruction through FETCH/DECODE/EXEC/MEM/WB states. In each state it drives RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, INT and the PC/IR enables. It also keeps a retired-instruction counter and halts on unsupported opcodes.

## Interface
- RETIRE_W, 32, width of the retired-instruction counter
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- ins  in  32  instruction word from yIF, valid during FETCH
- zero  in  1  ALU zero flag from yEX, valid in EXEC
- IRWrite  out  1  latch ins into the internal IR (FETCH only)
- PCWrite  out  1  update the PC register this cycle
- INT  out  1  force the PC to the entry point (INIT only)
- isbranch, isjump  out  1 each  PC-select qualifiers to yPC, valid while PCWrite=1
- RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out  1 each  datapath controls
- op  out  3  ALU operation to yEX
- halted  out  1  sticky illegal-opcode flag
- retired  out  RETIRE_W  count of completed instructions

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are Moore outputs, decoded from the state plus the latched IR. Every control output is 0 unless listed below.
- INIT:
  - INT=1 and PCWrite=1.
  - Next state is FETCH.
- FETCH:
  - IRWrite=1; the IR captures ins on the exiting edge.
  - Next state is DECODE.
- DECODE:
  - No controls asserted.
  - If IR[6:0] is not in {03,13,23,33,63,6F}, next state is HALT. Otherwise next state is EXEC.
- EXEC:
  - ALUSrc=0 for opcodes 33 and 63, else 1.
  - op by opcode:
    - 63 gives 110.
    - 33 decodes {funct7[5],funct3}: 0/000 add=010, 1/000 sub=110, 0/111 and=000, 0/110 or=001, 0/010 slt=111; any other R combination gives 010.
    - All other opcodes give 010.
  - ALUSrc and op stay held through MEM and WB of the same instruction.
  - Opcode 63: PCWrite=1, isbranch=1, then next state is FETCH. yPC resolves taken/not-taken from zero.
  - Opcodes 03 and 23: next state is MEM. All others: next state is WB.
- MEM:
  - Opcode 03: MemRead=1, then next state is WB.
  - Opcode 23: MemWrite=1 and PCWrite=1, then next state is FETCH.
- WB:
  - RegWrite=1 and PCWrite=1.
  - Opcode 03: Mem2Reg=1 and MemRead=1 (held).
  - Opcode 6F: isjump=1.
  - Next state is FETCH.
- retired increments by 1 on every edge leaving a state with PCWrite=1, except INIT. It wraps modulo 2^RETIRE_W.
- HALT:
  - halted=1 and all controls 0.
  - Remains in HALT until reset.

## Timing
- Reset values, held during reset and for the cycle in which reset=1 is sampled:
  - State becomes INIT.
  - retired=0, halted=0.
  - All other outputs are 0 except INT and PCWrite, which are 1 in INIT.
- INIT lasts exactly one cycle after reset deasserts.
- Cycles per instruction, FETCH through last state: branch 3, R/I-ALU/jal/sw 4, lw 5.
- PCWrite is high in exactly one cycle per instruction, always that instruction's final state.
- ins is sampled only in FETCH; changes to ins in other states have no effect.
- Reset asserted in any state, including mid-MEM of sw, forces INIT on the next edge. MemWrite and RegWrite are then 0 in that next cycle and no partial instruction retires.
- retired wrap: from 2^RETIRE_W−1, a retire gives 0.

## Test plan
- Reset for 2 cycles, then release:
  - INT=1 and PCWrite=1 for exactly one cycle.
  - Next cycle IRWrite=1.
  - retired=0.
- ins=0x00A38333 (add x6,x7,x10):
  - EXEC: ALUSrc=0, op=010.
  - WB: RegWrite=1, PCWrite=1.
  - retired increments by 1 after 4 cycles.
- ins=0x00002283 (lw), then 0x00502023 (sw):
  - lw: MEM has MemRead=1; WB has Mem2Reg=1 and RegWrite=1; 5 cycles total.
  - sw: MEM has MemWrite=1 and PCWrite=1; RegWrite=0 throughout; 4 cycles total.
- ins=0x00000063 (beq):
  - EXEC: op=110, ALUSrc=0, isbranch=1, PCWrite=1.
  - Next state is FETCH; 3 cycles total.
- ins=0x00000000:
  - DECODE leads to HALT; halted=1 on the next cycle.
  - All controls stay 0 for 10+ cycles; retired is unchanged.
  - Reset clears halted.
- Reset mid-instruction and counter wrap:
  - Assert reset in the MEM state of lw: next cycle is INIT, MemRead=0, retired=0.
  - Separately, with RETIRE_W=4, retire 16 instructions: retired reads 0.
